// File: rtl/fu_issue_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue_sched_pkg
// Purpose  : Shared types and constants for the issue scheduler: the
//            reservation-station row record, FU index constants, the row
//            count and a free-row counting helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fu_issue_sched_pkg;

  localparam int NUM_ENTRIES = 16;

  // Rows store tags zero-extended to this width so the record type does not
  // depend on the instantiating module's PREG_W (which must be <= this).
  localparam int MAX_PREG_W = 8;

  localparam logic [1:0] FU_ALU0    = 2'd0;
  localparam logic [1:0] FU_ALU1    = 2'd1;
  localparam logic [1:0] FU_MEM     = 2'd2;
  localparam logic [1:0] FU_ILLEGAL = 2'd3;

  typedef struct packed {
    logic                  valid;
    logic                  r1;
    logic                  r2;
    logic [MAX_PREG_W-1:0] ps1;
    logic [MAX_PREG_W-1:0] ps2;
    logic [MAX_PREG_W-1:0] pd;
    logic [1:0]            fu;
  } row_t;

  function automatic logic [4:0] count_free(input logic [NUM_ENTRIES-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!v[i]) cnt = cnt + 5'd1;
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fu_issue_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue_sched_if
// Purpose  : Bundle of allocation, wakeup, FU-ready and issue signals of the
//            issue scheduler.
// Ports    : master - dispatch/writeback/FU side (drives alloc_*, wb_*,
//                     fu_ready; observes alloc_idx_*, alloc_rdy, issue_*,
//                     free_cnt, err)
//            slave  - scheduler side (reverse directions)
// Revision : 1.0 - initial release
// ============================================================================
interface fu_issue_sched_if #(
  parameter int NUM_FU = 3,
  parameter int PREG_W = 6
);
  logic                     alloc_v_1;
  logic                     alloc_v_2;
  logic [PREG_W-1:0]        alloc_ps1_1;
  logic [PREG_W-1:0]        alloc_ps2_1;
  logic [PREG_W-1:0]        alloc_pd_1;
  logic [PREG_W-1:0]        alloc_ps1_2;
  logic [PREG_W-1:0]        alloc_ps2_2;
  logic [PREG_W-1:0]        alloc_pd_2;
  logic                     alloc_r1_1;
  logic                     alloc_r2_1;
  logic                     alloc_r1_2;
  logic                     alloc_r2_2;
  logic [1:0]               alloc_fu_1;
  logic [1:0]               alloc_fu_2;
  logic [3:0]               alloc_idx_1;
  logic [3:0]               alloc_idx_2;
  logic [1:0]               alloc_rdy;
  logic [NUM_FU-1:0]        wb_v;
  logic [NUM_FU*PREG_W-1:0] wb_tag;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU-1:0]        issue_v;
  logic [NUM_FU*4-1:0]      issue_idx;
  logic [4:0]               free_cnt;
  logic                     err;

  modport master (
    output alloc_v_1, alloc_v_2,
    output alloc_ps1_1, alloc_ps2_1, alloc_pd_1,
    output alloc_ps1_2, alloc_ps2_2, alloc_pd_2,
    output alloc_r1_1, alloc_r2_1, alloc_r1_2, alloc_r2_2,
    output alloc_fu_1, alloc_fu_2,
    output wb_v, wb_tag, fu_ready,
    input  alloc_idx_1, alloc_idx_2, alloc_rdy,
    input  issue_v, issue_idx, free_cnt, err
  );

  modport slave (
    input  alloc_v_1, alloc_v_2,
    input  alloc_ps1_1, alloc_ps2_1, alloc_pd_1,
    input  alloc_ps1_2, alloc_ps2_2, alloc_pd_2,
    input  alloc_r1_1, alloc_r2_1, alloc_r1_2, alloc_r2_2,
    input  alloc_fu_1, alloc_fu_2,
    input  wb_v, wb_tag, fu_ready,
    output alloc_idx_1, alloc_idx_2, alloc_rdy,
    output issue_v, issue_idx, free_cnt, err
  );
endinterface
`default_nettype wire

// File: rtl/fu_issue_sched_rr_pick16.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick16
// Purpose  : 16-way round-robin picker. Searches i_req starting at row
//            i_base and wrapping, returning the first requesting row.
// Ports    : i_req     - request vector, one bit per row
//            i_base    - row where the search starts
//            o_gnt_v   - a request was found
//            o_gnt_idx - granted row (0 when none)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick16 (
  input  logic [15:0] i_req,
  input  logic [3:0]  i_base,
  output logic        o_gnt_v,
  output logic [3:0]  o_gnt_idx
);

  always_comb begin
    o_gnt_v   = 1'b0;
    o_gnt_idx = '0;
    for (int k = 0; k < 16; k++) begin
      // 4-bit sum wraps naturally past row 15.
      if (!o_gnt_v && i_req[i_base + 4'(k)]) begin
        o_gnt_v   = 1'b1;
        o_gnt_idx = i_base + 4'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue_sched
// Purpose  : 16-row reservation-station issue scheduler. Two allocation
//            slots per cycle, tag-broadcast wakeup, and one round-robin
//            issue selection per functional unit with registered issue
//            outputs. FU 2 is the memory unit; FU index 3 is illegal and
//            sets a sticky error.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - fu_issue_sched_if.slave (alloc_*, wb_*, fu_ready in;
//                   alloc_idx_*, alloc_rdy, issue_*, free_cnt, err out)
// Config   : SCHED_WAKEUP_BYPASS_EN - when defined, a wakeup broadcast in
//            cycle N makes a row eligible in cycle N instead of N+1.
// Revision : 1.0 - initial release
// ============================================================================
module fu_issue_sched #(
  parameter int NUM_ENTRIES = fu_issue_sched_pkg::NUM_ENTRIES,
  parameter int NUM_FU      = 3,
  parameter int PREG_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  fu_issue_sched_if.slave   bus
);
  import fu_issue_sched_pkg::*;

  function automatic logic [MAX_PREG_W-1:0] ext_tag(input logic [PREG_W-1:0] t);
    logic [MAX_PREG_W-1:0] e;
    e            = '0;
    e[PREG_W-1:0] = t;
    return e;
  endfunction

  row_t                    r_rows     [NUM_ENTRIES];
  row_t                    w_rows_nxt [NUM_ENTRIES];
  row_t                    w_new_1;
  row_t                    w_new_2;
  logic [NUM_ENTRIES-1:0]  w_valid;
  logic [NUM_ENTRIES-1:0]  w_valid_nxt;
  logic [NUM_ENTRIES-1:0]  w_hit1;
  logic [NUM_ENTRIES-1:0]  w_hit2;
  logic [NUM_ENTRIES-1:0]  w_elig;
  logic                    w_ahit1_1, w_ahit2_1, w_ahit1_2, w_ahit2_2;
  logic                    w_found_1, w_found_2;
  logic [3:0]              w_idx_1, w_idx_2;
  logic                    w_take_1, w_take_2, w_err_set;
  logic [NUM_FU-1:0]       w_gnt_v;
  logic [NUM_FU-1:0][3:0]  w_gnt_idx;

  logic [NUM_FU-1:0]       r_issue_v;
  logic [NUM_FU-1:0][3:0]  r_issue_idx;
  logic [NUM_FU-1:0][3:0]  r_rr_ptr;
  logic [4:0]              r_free_cnt;
  logic                    r_err;

  // Free-row search: first two invalid rows from the registered state.
  always_comb begin
    w_found_1 = 1'b0;
    w_found_2 = 1'b0;
    w_idx_1   = '0;
    w_idx_2   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_valid[i] = r_rows[i].valid;
      if (!r_rows[i].valid) begin
        if (!w_found_1) begin
          w_found_1 = 1'b1;
          w_idx_1   = i[3:0];
        end else if (!w_found_2) begin
          w_found_2 = 1'b1;
          w_idx_2   = i[3:0];
        end
      end
    end
  end

  // Wakeup tag match against resident rows and against the rows being
  // allocated this cycle, so an op never misses a same-cycle broadcast.
  always_comb begin
    w_hit1    = '0;
    w_hit2    = '0;
    w_ahit1_1 = 1'b0;
    w_ahit2_1 = 1'b0;
    w_ahit1_2 = 1'b0;
    w_ahit2_2 = 1'b0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (bus.wb_v[f]) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (r_rows[i].valid && r_rows[i].ps1 == ext_tag(bus.wb_tag[f*PREG_W +: PREG_W])) w_hit1[i] = 1'b1;
          if (r_rows[i].valid && r_rows[i].ps2 == ext_tag(bus.wb_tag[f*PREG_W +: PREG_W])) w_hit2[i] = 1'b1;
        end
        if (bus.alloc_ps1_1 == bus.wb_tag[f*PREG_W +: PREG_W]) w_ahit1_1 = 1'b1;
        if (bus.alloc_ps2_1 == bus.wb_tag[f*PREG_W +: PREG_W]) w_ahit2_1 = 1'b1;
        if (bus.alloc_ps1_2 == bus.wb_tag[f*PREG_W +: PREG_W]) w_ahit1_2 = 1'b1;
        if (bus.alloc_ps2_2 == bus.wb_tag[f*PREG_W +: PREG_W]) w_ahit2_2 = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
`ifdef SCHED_WAKEUP_BYPASS_EN
      w_elig[i] = r_rows[i].valid && (r_rows[i].r1 || w_hit1[i]) && (r_rows[i].r2 || w_hit2[i]);
`else
      w_elig[i] = r_rows[i].valid && r_rows[i].r1 && r_rows[i].r2;
`endif
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
    logic [15:0] w_req;
    always_comb begin
      w_req = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        w_req[i] = w_elig[i] && (r_rows[i].fu == 2'(f)) && bus.fu_ready[f];
      end
    end
    rr_pick16 u_pick (
      .i_req     (w_req),
      .i_base    (r_rr_ptr[f]),
      .o_gnt_v   (w_gnt_v[f]),
      .o_gnt_idx (w_gnt_idx[f])
    );
  end

  // Allocation: illegal FU requests are dropped and only raise err.
  always_comb begin
    w_take_1  = bus.alloc_v_1 && w_found_1 && (bus.alloc_fu_1 != FU_ILLEGAL);
    w_take_2  = bus.alloc_v_2 && w_found_2 && (bus.alloc_fu_2 != FU_ILLEGAL);
    w_err_set = (bus.alloc_v_1 && w_found_1 && (bus.alloc_fu_1 == FU_ILLEGAL)) ||
                (bus.alloc_v_2 && w_found_2 && (bus.alloc_fu_2 == FU_ILLEGAL));

    w_new_1       = '0;
    w_new_1.valid = 1'b1;
    w_new_1.r1    = bus.alloc_r1_1 || w_ahit1_1;
    w_new_1.r2    = bus.alloc_r2_1 || w_ahit2_1;
    w_new_1.ps1   = ext_tag(bus.alloc_ps1_1);
    w_new_1.ps2   = ext_tag(bus.alloc_ps2_1);
    w_new_1.pd    = ext_tag(bus.alloc_pd_1);
    w_new_1.fu    = bus.alloc_fu_1;

    w_new_2       = '0;
    w_new_2.valid = 1'b1;
    w_new_2.r1    = bus.alloc_r1_2 || w_ahit1_2;
    w_new_2.r2    = bus.alloc_r2_2 || w_ahit2_2;
    w_new_2.ps1   = ext_tag(bus.alloc_ps1_2);
    w_new_2.ps2   = ext_tag(bus.alloc_ps2_2);
    w_new_2.pd    = ext_tag(bus.alloc_pd_2);
    w_new_2.fu    = bus.alloc_fu_2;
  end

  // Next row state: wakeup, then issue clears, then allocation. Granted and
  // allocated rows never coincide because allocation only targets rows that
  // are invalid in the registered state.
  always_comb begin
    w_rows_nxt = r_rows;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_hit1[i]) w_rows_nxt[i].r1 = 1'b1;
      if (w_hit2[i]) w_rows_nxt[i].r2 = 1'b1;
    end
    for (int f = 0; f < NUM_FU; f++) begin
      if (w_gnt_v[f]) w_rows_nxt[w_gnt_idx[f]].valid = 1'b0;
    end
    if (w_take_1) w_rows_nxt[w_idx_1] = w_new_1;
    if (w_take_2) w_rows_nxt[w_idx_2] = w_new_2;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_valid_nxt[i] = w_rows_nxt[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_rows[i] <= '0;
      r_issue_v   <= '0;
      r_issue_idx <= '0;
      r_rr_ptr    <= '0;
      r_free_cnt  <= 5'(NUM_ENTRIES);
      r_err       <= 1'b0;
    end else begin
      r_rows      <= w_rows_nxt;
      r_issue_v   <= w_gnt_v;
      r_issue_idx <= w_gnt_idx;
      for (int f = 0; f < NUM_FU; f++) begin
        if (w_gnt_v[f]) r_rr_ptr[f] <= w_gnt_idx[f] + 4'd1;
      end
      r_free_cnt  <= count_free(w_valid_nxt);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.alloc_idx_1 = w_idx_1;
  assign bus.alloc_idx_2 = w_idx_2;
  assign bus.alloc_rdy   = {w_found_2, w_found_1};
  assign bus.issue_v     = r_issue_v;
  assign bus.issue_idx   = r_issue_idx;
  assign bus.free_cnt    = r_free_cnt;
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_issue_sched
// Purpose  : Self-checking bench for fu_issue_sched: directed scenarios plus
//            randomized traffic compared against a row-array reference model.
// Config   : honours SCHED_WAKEUP_BYPASS_EN for wakeup latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_issue_sched;
  localparam int NE = 16;
  localparam int NF = 3;
  localparam int PW = 6;
`ifdef SCHED_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fu_issue_sched_if #(.NUM_FU(NF), .PREG_W(PW)) bus ();

  fu_issue_sched #(.NUM_ENTRIES(NE), .NUM_FU(NF), .PREG_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: one record per row plus per-FU search start.
  bit m_v  [NE];
  bit m_r1 [NE];
  bit m_r2 [NE];
  int m_ps1[NE];
  int m_ps2[NE];
  int m_fu [NE];
  int m_start [NF];
  bit m_err;
  bit m_iss_v  [NF];
  int m_iss_idx[NF];

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_ps1[i] = 0; m_ps2[i] = 0; m_fu[i] = 0;
    end
    for (int f = 0; f < NF; f++) begin
      m_start[f] = 0; m_iss_v[f] = 0; m_iss_idx[f] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_free(output int f1, output int f2, output int cnt);
    f1 = -1; f2 = -1; cnt = 0;
    for (int i = 0; i < NE; i++) begin
      if (!m_v[i]) begin
        if (cnt == 0) f1 = i;
        else if (cnt == 1) f2 = i;
        cnt++;
      end
    end
  endtask

  task automatic model_step();
    bit h1[NE];
    bit h2[NE];
    bit s_v[NF];
    int s_idx[NF];
    bit ah[4];
    int f1, f2, cnt, tag;
    if (rst) begin
      model_reset();
      return;
    end
    model_free(f1, f2, cnt);
    for (int i = 0; i < NE; i++) begin h1[i] = 0; h2[i] = 0; end
    for (int j = 0; j < 4; j++) ah[j] = 0;
    for (int f = 0; f < NF; f++) begin
      if (bus.wb_v[f]) begin
        tag = int'(bus.wb_tag[f*PW +: PW]);
        for (int i = 0; i < NE; i++) begin
          if (m_v[i] && m_ps1[i] == tag) h1[i] = 1;
          if (m_v[i] && m_ps2[i] == tag) h2[i] = 1;
        end
        if (int'(bus.alloc_ps1_1) == tag) ah[0] = 1;
        if (int'(bus.alloc_ps2_1) == tag) ah[1] = 1;
        if (int'(bus.alloc_ps1_2) == tag) ah[2] = 1;
        if (int'(bus.alloc_ps2_2) == tag) ah[3] = 1;
      end
    end
    for (int f = 0; f < NF; f++) begin
      s_v[f] = 0; s_idx[f] = 0;
      if (bus.fu_ready[f]) begin
        for (int k = 0; k < NE; k++) begin
          int r;
          r = (m_start[f] + k) % NE;
          if (!s_v[f] && m_v[r] && m_fu[r] == f &&
              (m_r1[r] || (BYP && h1[r])) && (m_r2[r] || (BYP && h2[r]))) begin
            s_v[f] = 1; s_idx[f] = r;
          end
        end
      end
    end
    for (int i = 0; i < NE; i++) begin
      if (h1[i]) m_r1[i] = 1;
      if (h2[i]) m_r2[i] = 1;
    end
    for (int f = 0; f < NF; f++) begin
      m_iss_v[f] = s_v[f]; m_iss_idx[f] = s_idx[f];
      if (s_v[f]) begin
        m_v[s_idx[f]] = 0;
        m_start[f] = (s_idx[f] + 1) % NE;
      end
    end
    if (bus.alloc_v_1 && cnt >= 1) begin
      if (bus.alloc_fu_1 == 2'd3) m_err = 1;
      else begin
        m_v[f1] = 1; m_r1[f1] = bus.alloc_r1_1 | ah[0]; m_r2[f1] = bus.alloc_r2_1 | ah[1];
        m_ps1[f1] = int'(bus.alloc_ps1_1); m_ps2[f1] = int'(bus.alloc_ps2_1); m_fu[f1] = int'(bus.alloc_fu_1);
      end
    end
    if (bus.alloc_v_2 && cnt >= 2) begin
      if (bus.alloc_fu_2 == 2'd3) m_err = 1;
      else begin
        m_v[f2] = 1; m_r1[f2] = bus.alloc_r1_2 | ah[2]; m_r2[f2] = bus.alloc_r2_2 | ah[3];
        m_ps1[f2] = int'(bus.alloc_ps1_2); m_ps2[f2] = int'(bus.alloc_ps2_2); m_fu[f2] = int'(bus.alloc_fu_2);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_v_1 = 0; bus.alloc_v_2 = 0;
    bus.alloc_ps1_1 = '0; bus.alloc_ps2_1 = '0; bus.alloc_pd_1 = '0;
    bus.alloc_ps1_2 = '0; bus.alloc_ps2_2 = '0; bus.alloc_pd_2 = '0;
    bus.alloc_r1_1 = 0; bus.alloc_r2_1 = 0; bus.alloc_r1_2 = 0; bus.alloc_r2_2 = 0;
    bus.alloc_fu_1 = '0; bus.alloc_fu_2 = '0;
    bus.wb_v = '0; bus.wb_tag = '0; bus.fu_ready = '1;
  endtask

  task automatic drive_slot(input int k, input bit r1, input bit r2, input int ps1, input int ps2, input int fu);
    if (k == 1) begin
      bus.alloc_v_1 = 1; bus.alloc_r1_1 = r1; bus.alloc_r2_1 = r2;
      bus.alloc_ps1_1 = 6'(ps1); bus.alloc_ps2_1 = 6'(ps2); bus.alloc_pd_1 = 6'(ps1 + 20);
      bus.alloc_fu_1 = 2'(fu);
    end else begin
      bus.alloc_v_2 = 1; bus.alloc_r1_2 = r1; bus.alloc_r2_2 = r2;
      bus.alloc_ps1_2 = 6'(ps1); bus.alloc_ps2_2 = 6'(ps2); bus.alloc_pd_2 = 6'(ps1 + 30);
      bus.alloc_fu_2 = 2'(fu);
    end
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); tick(); tick(); rst = 0;
    n_checks++; if (bus.issue_v !== 3'b000) begin n_fail++; $display("FAIL reset_issue_v: got %b expected 000", bus.issue_v); end
    n_checks++; if (bus.free_cnt !== 5'd16) begin n_fail++; $display("FAIL reset_free_cnt: got %0d expected 16", bus.free_cnt); end
    n_checks++; if (bus.alloc_rdy !== 2'b11) begin n_fail++; $display("FAIL reset_alloc_rdy: got %b expected 11", bus.alloc_rdy); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_checks++; if (bus.alloc_idx_1 !== 4'd0 || bus.alloc_idx_2 !== 4'd1) begin
      n_fail++; $display("FAIL reset_alloc_idx: got %0d/%0d expected 0/1", bus.alloc_idx_1, bus.alloc_idx_2); end
  endtask

  task automatic test_alloc_pair();
    do_reset();
    drive_slot(1, 1, 1, 1, 2, 0);
    drive_slot(2, 1, 1, 3, 4, 1);
    n_checks++; if (bus.alloc_idx_1 !== 4'd0 || bus.alloc_idx_2 !== 4'd1) begin
      n_fail++; $display("FAIL pair_alloc_idx: got %0d/%0d expected 0/1", bus.alloc_idx_1, bus.alloc_idx_2); end
    tick(); idle_inputs();
    n_checks++; if (bus.issue_v !== 3'b000 || bus.free_cnt !== 5'd14) begin
      n_fail++; $display("FAIL pair_cycle1: got issue_v=%b free=%0d expected 000/14", bus.issue_v, bus.free_cnt); end
    tick();
    n_checks++; if (bus.issue_v !== 3'b011) begin n_fail++; $display("FAIL pair_issue_v: got %b expected 011", bus.issue_v); end
    n_checks++; if (bus.issue_idx[3:0] !== 4'd0 || bus.issue_idx[7:4] !== 4'd1) begin
      n_fail++; $display("FAIL pair_issue_idx: got %h expected fu0=0 fu1=1", bus.issue_idx); end
    n_checks++; if (bus.free_cnt !== 5'd16) begin n_fail++; $display("FAIL pair_free_back: got %0d expected 16", bus.free_cnt); end
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle_inputs(); bus.fu_ready = '0;
      drive_slot(1, 1, 1, c, c, 0); drive_slot(2, 1, 1, c, c, 0);
      tick();
    end
    idle_inputs(); bus.fu_ready = '0; drive_slot(1, 1, 1, 5, 5, 0); tick();
    idle_inputs(); bus.fu_ready = '0;
    n_checks++; if (bus.alloc_rdy !== 2'b01 || bus.free_cnt !== 5'd1 || bus.alloc_idx_1 !== 4'd15) begin
      n_fail++; $display("FAIL full15: got rdy=%b free=%0d idx=%0d expected 01/1/15", bus.alloc_rdy, bus.free_cnt, bus.alloc_idx_1); end
    drive_slot(1, 1, 1, 6, 6, 0); tick();
    idle_inputs(); bus.fu_ready = '0;
    n_checks++; if (bus.alloc_rdy !== 2'b00 || bus.free_cnt !== 5'd0) begin
      n_fail++; $display("FAIL full16: got rdy=%b free=%0d expected 00/0", bus.alloc_rdy, bus.free_cnt); end
    drive_slot(1, 1, 1, 7, 7, 3); drive_slot(2, 1, 1, 7, 7, 0); tick();
    idle_inputs(); bus.fu_ready = '0;
    n_checks++; if (bus.free_cnt !== 5'd0 || bus.err !== 1'b0 || bus.issue_v !== 3'b000) begin
      n_fail++; $display("FAIL full_ignored: got free=%0d err=%b issue_v=%b expected 0/0/000", bus.free_cnt, bus.err, bus.issue_v); end
  endtask

  task automatic test_wakeup();
    do_reset();
    drive_slot(1, 0, 1, 9, 0, 0); tick(); idle_inputs();
    bus.wb_v = 3'b001; bus.wb_tag = {12'd0, 6'd8}; tick(); idle_inputs();
    tick();
    n_checks++; if (bus.issue_v !== 3'b000) begin n_fail++; $display("FAIL wake_wrong_tag: got %b expected 000", bus.issue_v); end
    bus.wb_v = 3'b001; bus.wb_tag = {12'd0, 6'd9}; tick(); idle_inputs();
`ifdef SCHED_WAKEUP_BYPASS_EN
    n_checks++; if (bus.issue_v !== 3'b001 || bus.issue_idx[3:0] !== 4'd0) begin
      n_fail++; $display("FAIL wake_bypass_issue: got v=%b idx=%h expected 001/0", bus.issue_v, bus.issue_idx); end
`else
    n_checks++; if (bus.issue_v !== 3'b000) begin n_fail++; $display("FAIL wake_too_early: got %b expected 000", bus.issue_v); end
    tick();
    n_checks++; if (bus.issue_v !== 3'b001 || bus.issue_idx[3:0] !== 4'd0) begin
      n_fail++; $display("FAIL wake_issue: got v=%b idx=%h expected 001/0", bus.issue_v, bus.issue_idx); end
`endif
    n_checks++; if (bus.free_cnt !== 5'd16) begin n_fail++; $display("FAIL wake_free: got %0d expected 16", bus.free_cnt); end
  endtask

  task automatic test_rr_order();
    do_reset();
    bus.fu_ready = '0;
    drive_slot(1, 1, 1, 1, 1, 0); drive_slot(2, 1, 1, 2, 2, 0); tick();
    idle_inputs(); bus.fu_ready = '0; drive_slot(1, 1, 1, 3, 3, 0); tick();
    idle_inputs(); bus.fu_ready = '0; tick(); tick();
    n_checks++; if (bus.issue_v !== 3'b000 || bus.free_cnt !== 5'd13) begin
      n_fail++; $display("FAIL rr_not_ready: got v=%b free=%0d expected 000/13", bus.issue_v, bus.free_cnt); end
    bus.fu_ready = 3'b001;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (bus.issue_v !== 3'b001 || bus.issue_idx[3:0] !== 4'(k)) begin
        n_fail++; $display("FAIL rr_order_%0d: got v=%b idx=%0d expected 001/%0d", k, bus.issue_v, bus.issue_idx[3:0], k); end
    end
    tick();
    n_checks++; if (bus.issue_v !== 3'b000 || bus.free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL rr_drained: got v=%b free=%0d expected 000/16", bus.issue_v, bus.free_cnt); end
  endtask

  task automatic test_err_and_reset();
    do_reset();
    drive_slot(1, 1, 1, 4, 4, 3); tick(); idle_inputs();
    n_checks++; if (bus.err !== 1'b1 || bus.free_cnt !== 5'd16) begin
      n_fail++; $display("FAIL err_set: got err=%b free=%0d expected 1/16", bus.err, bus.free_cnt); end
    tick();
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
    drive_slot(1, 1, 1, 5, 5, 2); tick(); idle_inputs();
    drive_slot(1, 1, 1, 6, 6, 0); rst = 1; tick(); rst = 0; idle_inputs();
    n_checks++; if (bus.issue_v !== 3'b000 || bus.free_cnt !== 5'd16 || bus.err !== 1'b0 || bus.alloc_rdy !== 2'b11) begin
      n_fail++; $display("FAIL mid_reset: got v=%b free=%0d err=%b rdy=%b expected 000/16/0/11",
                         bus.issue_v, bus.free_cnt, bus.err, bus.alloc_rdy); end
  endtask

  task automatic test_random();
    int f1, f2, cnt;
    logic [1:0] exp_rdy;
    int free_exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) drive_slot(1, 1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                                                ($urandom_range(0, 39) == 0) ? 3 : $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) drive_slot(2, 1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                                                ($urandom_range(0, 39) == 0) ? 3 : $urandom_range(0, 2));
      for (int f = 0; f < NF; f++) begin
        bus.wb_v[f]            = ($urandom_range(0, 9) < 3);
        bus.wb_tag[f*PW +: PW] = 6'($urandom_range(0, 7));
        bus.fu_ready[f]        = ($urandom_range(0, 9) < 7);
      end
      #1;
      model_free(f1, f2, cnt);
      exp_rdy = {cnt >= 2, cnt >= 1};
      n_checks++; if (bus.alloc_rdy !== exp_rdy) begin
        n_fail++; $display("FAIL rnd_alloc_rdy c=%0d: got %b expected %b", c, bus.alloc_rdy, exp_rdy); end
      if (cnt >= 1) begin
        n_checks++; if (bus.alloc_idx_1 !== 4'(f1)) begin
          n_fail++; $display("FAIL rnd_alloc_idx_1 c=%0d: got %0d expected %0d", c, bus.alloc_idx_1, f1); end
      end
      if (cnt >= 2) begin
        n_checks++; if (bus.alloc_idx_2 !== 4'(f2)) begin
          n_fail++; $display("FAIL rnd_alloc_idx_2 c=%0d: got %0d expected %0d", c, bus.alloc_idx_2, f2); end
      end
      tick();
      rst = 0;
      for (int f = 0; f < NF; f++) begin
        n_checks++; if (bus.issue_v[f] !== m_iss_v[f]) begin
          n_fail++; $display("FAIL rnd_issue_v c=%0d fu=%0d: got %b expected %b", c, f, bus.issue_v[f], m_iss_v[f]); end
        if (m_iss_v[f]) begin
          n_checks++; if (bus.issue_idx[f*4 +: 4] !== 4'(m_iss_idx[f])) begin
            n_fail++; $display("FAIL rnd_issue_idx c=%0d fu=%0d: got %0d expected %0d", c, f, bus.issue_idx[f*4 +: 4], m_iss_idx[f]); end
        end
      end
      free_exp = 0;
      for (int i = 0; i < NE; i++) if (!m_v[i]) free_exp++;
      n_checks++; if (bus.free_cnt !== 5'(free_exp)) begin
        n_fail++; $display("FAIL rnd_free_cnt c=%0d: got %0d expected %0d", c, bus.free_cnt, free_exp); end
      n_checks++; if (bus.err !== m_err) begin
        n_fail++; $display("FAIL rnd_err c=%0d: got %b expected %b", c, bus.err, m_err); end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_alloc_pair();
    test_full();
    test_wakeup();
    test_rr_order();
    test_err_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
